// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA rectangle overlay blocks.
package vga_pkg;

    // Width of a colour code understood by vga_colour.
    localparam int COLOUR_W = 5;

    // Coordinates are stored at this fixed width inside a rectangle record.
    // Narrower pixel coordinates are zero-extended, so COORD_W of any user
    // must not exceed this value.
    localparam int RECT_COORD_W = 16;

    // Draw mode of one rectangle slot.
    typedef enum logic [1:0] {
        MODE_SOLID = 2'b00,
        MODE_DASH  = 2'b01,
        MODE_FILL  = 2'b10,
        MODE_OFF   = 2'b11
    } rect_mode_e;

    // One programmable rectangle: (x0,y0) top-left, (x1,y1) bottom-right.
    typedef struct packed {
        logic [RECT_COORD_W-1:0] x0;
        logic [RECT_COORD_W-1:0] x1;
        logic [RECT_COORD_W-1:0] y0;
        logic [RECT_COORD_W-1:0] y1;
        logic [COLOUR_W-1:0]     colour;
        rect_mode_e              mode;
    } rect_t;

    // Value every slot takes after reset: switched off, all fields zero.
    localparam rect_t RECT_RESET = '{
        x0:     '0,
        x1:     '0,
        y0:     '0,
        y1:     '0,
        colour: '0,
        mode:   MODE_OFF
    };

endpackage

// File: rtl/vga_colour.sv
// Colour-code to RGB lookup used on the overlay path.
// Code 0 is transparent (c_mask_o=0). Codes 1..15 are the eight RGB corner
// colours, full intensity for 1..7 and half intensity for 8..15 (bit 3 set).
// Codes 16..31 are a 16-step grey ramp.
module vga_colour
    import vga_pkg::*;
(
    input  logic [COLOUR_W-1:0] code_i,
    output logic [7:0]          r_o,
    output logic [7:0]          g_o,
    output logic [7:0]          b_o,
    output logic                c_mask_o
);

    logic [7:0] level;

    // Decode the colour code into channel intensities and an opacity flag.
    always_comb begin
        level    = code_i[3] ? 8'h80 : 8'hFF;
        c_mask_o = (code_i != '0);
        r_o      = 8'h00;
        g_o      = 8'h00;
        b_o      = 8'h00;
        if (code_i[4]) begin
            r_o = {code_i[3:0], code_i[3:0]};
            g_o = {code_i[3:0], code_i[3:0]};
            b_o = {code_i[3:0], code_i[3:0]};
        end else begin
            r_o = code_i[0] ? level : 8'h00;
            g_o = code_i[1] ? level : 8'h00;
            b_o = code_i[2] ? level : 8'h00;
        end
    end

endmodule

// File: rtl/vga_rect_hit.sv
// Combinational hit test of one pixel against one rectangle slot.
// Compares are unsigned; an inverted extent (x0>x1 or y0>y1) never hits.
module vga_rect_hit
    import vga_pkg::*;
#(
    parameter int DASH_LOG2 = 2
) (
    input  rect_t                   rect_i,
    input  logic [RECT_COORD_W-1:0] x_i,
    input  logic [RECT_COORD_W-1:0] y_i,
    output logic                    hit_o
);

    logic inRect;
    logic onHoriz;
    logic onVert;
    logic onEdge;
    logic dashXBit;
    logic dashYBit;
    logic dashOn;

    // The dash phase only needs one bit of each offset from the top-left
    // corner; the low bits of a difference are the same at any modulus.
    assign dashXBit = 1'((x_i - rect_i.x0) >> DASH_LOG2);
    assign dashYBit = 1'((y_i - rect_i.y0) >> DASH_LOG2);

    // Geometry test, then mode selection.
    always_comb begin
        inRect  = (x_i >= rect_i.x0) && (x_i <= rect_i.x1) &&
                  (y_i >= rect_i.y0) && (y_i <= rect_i.y1);
        onHoriz = (y_i == rect_i.y0) || (y_i == rect_i.y1);
        onVert  = (x_i == rect_i.x0) || (x_i == rect_i.x1);
        onEdge  = inRect && (onHoriz || onVert);
        dashOn  = onHoriz ? ~dashXBit : ~dashYBit;
        hit_o   = 1'b0;
        case (rect_i.mode)
            MODE_SOLID: hit_o = onEdge;
            MODE_DASH:  hit_o = onEdge && dashOn;
            MODE_FILL:  hit_o = inRect;
            default:    hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vga_rect_multi.sv
// Multi-rectangle overlay generator. Rectangles are written into a pending
// bank and copied to the active bank at frame start, so a frame never shows a
// half-updated set. Output is two clocks behind xin/yin with a valid flag.
module vga_rect_multi
    import vga_pkg::*;
#(
    parameter  int NUM_RECTS = 4,
    parameter  int COORD_W   = 10,
    parameter  int DASH_LOG2 = 2,
    localparam int IDX_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COORD_W-1:0]  xin,
    input  logic [COORD_W-1:0]  yin,
    input  logic                frame_start,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [COORD_W-1:0]  wr_x0,
    input  logic [COORD_W-1:0]  wr_x1,
    input  logic [COORD_W-1:0]  wr_y0,
    input  logic [COORD_W-1:0]  wr_y1,
    input  logic [COLOUR_W-1:0] wr_colour,
    input  logic [1:0]          wr_mode,
    output logic                commit_pending,
    output logic [7:0]          out_r,
    output logic [7:0]          out_g,
    output logic [7:0]          out_b,
    output logic                out_valid
);

    rect_t                   pendingBank_q [NUM_RECTS];
    rect_t                   activeBank_q  [NUM_RECTS];
    logic                    commitPending_q;

    rect_t                   wrRect;
    logic                    wrIdxOk;

    logic [RECT_COORD_W-1:0] xExt;
    logic [RECT_COORD_W-1:0] yExt;
    logic [NUM_RECTS-1:0]    hitVec;

    logic                    hitAny_d;
    logic [COLOUR_W-1:0]     hitColour_d;
    logic                    hitAny_q;
    logic [COLOUR_W-1:0]     hitColour_q;

    logic [7:0]              palR;
    logic [7:0]              palG;
    logic [7:0]              palB;
    logic                    palMask;
    logic                    pixelOn;

    logic                    outValid_q;
    logic [7:0]              outR_q;
    logic [7:0]              outG_q;
    logic [7:0]              outB_q;

    assign xExt = RECT_COORD_W'(xin);
    assign yExt = RECT_COORD_W'(yin);

    // Assemble the record being written; out-of-range slots are dropped.
    always_comb begin
        wrRect        = RECT_RESET;
        wrRect.x0     = RECT_COORD_W'(wr_x0);
        wrRect.x1     = RECT_COORD_W'(wr_x1);
        wrRect.y0     = RECT_COORD_W'(wr_y0);
        wrRect.y1     = RECT_COORD_W'(wr_y1);
        wrRect.colour = wr_colour;
        wrRect.mode   = rect_mode_e'(wr_mode);
        wrIdxOk       = (32'(wr_idx) < NUM_RECTS);
    end

    // Pending/active banks. A commit reads the pending registers before this
    // edge's write lands, so a same-cycle write waits for the next commit and
    // keeps commit_pending set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                pendingBank_q[i] <= RECT_RESET;
                activeBank_q[i]  <= RECT_RESET;
            end
            commitPending_q <= 1'b0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_RECTS; i++) begin
                    activeBank_q[i] <= pendingBank_q[i];
                end
            end
            if (wr_en && wrIdxOk) begin
                pendingBank_q[wr_idx] <= wrRect;
                commitPending_q       <= 1'b1;
            end else if (frame_start) begin
                commitPending_q <= 1'b0;
            end
        end
    end

    assign commit_pending = commitPending_q;

    // One hit tester per active slot.
    for (genvar g = 0; g < NUM_RECTS; g++) begin : gen_hit
        vga_rect_hit #(
            .DASH_LOG2 (DASH_LOG2)
        ) u_hit (
            .rect_i (activeBank_q[g]),
            .x_i    (xExt),
            .y_i    (yExt),
            .hit_o  (hitVec[g])
        );
    end

    // Priority select: scanning from the top slot down leaves the lowest
    // hitting index as the winner.
    always_comb begin
        hitAny_d    = 1'b0;
        hitColour_d = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (hitVec[i]) begin
                hitAny_d    = 1'b1;
                hitColour_d = activeBank_q[i].colour;
            end
        end
    end

    // Stage 1: register the hit flag and winning colour code.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitAny_q    <= 1'b0;
            hitColour_q <= '0;
        end else begin
            hitAny_q    <= hitAny_d;
            hitColour_q <= hitColour_d;
        end
    end

    vga_colour u_colour (
        .code_i   (hitColour_q),
        .r_o      (palR),
        .g_o      (palG),
        .b_o      (palB),
        .c_mask_o (palMask)
    );

    assign pixelOn = hitAny_q && palMask;

    // Stage 2: register the final pixel; colour is forced to zero when the
    // overlay has nothing opaque to show.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outR_q     <= 8'h00;
            outG_q     <= 8'h00;
            outB_q     <= 8'h00;
        end else begin
            outValid_q <= pixelOn;
            outR_q     <= pixelOn ? palR : 8'h00;
            outG_q     <= pixelOn ? palG : 8'h00;
            outB_q     <= pixelOn ? palB : 8'h00;
        end
    end

    assign out_valid = outValid_q;
    assign out_r     = outR_q;
    assign out_g     = outG_q;
    assign out_b     = outB_q;

endmodule

// File: tb/tb_vga_rect_multi.sv
// Directed bench for vga_rect_multi: drives pixel sweeps and rectangle writes
// and compares the delayed overlay output against hand-derived scenes.
module tb_vga_rect_multi;

    localparam int NUM_RECTS = 4;
    localparam int COORD_W   = 10;
    localparam int DASH_LOG2 = 2;
    localparam int IDX_W     = 2;

    localparam int M_SOLID = 0;
    localparam int M_DASH  = 1;
    localparam int M_FILL  = 2;
    localparam int M_OFF   = 3;

    // Expected {valid, r, g, b} for the colour codes used below.
    localparam logic [24:0] PIX_NONE  = 25'h0;
    localparam logic [24:0] PIX_RED   = {1'b1, 24'hFF0000};
    localparam logic [24:0] PIX_GREEN = {1'b1, 24'h00FF00};
    localparam logic [24:0] PIX_BLUE  = {1'b1, 24'h0000FF};
    localparam logic [24:0] PIX_WHITE = {1'b1, 24'hFFFFFF};

    logic               clk = 1'b0;
    logic               rst;
    logic [COORD_W-1:0] xin;
    logic [COORD_W-1:0] yin;
    logic               frame_start;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [COORD_W-1:0] wr_x0;
    logic [COORD_W-1:0] wr_x1;
    logic [COORD_W-1:0] wr_y0;
    logic [COORD_W-1:0] wr_y1;
    logic [4:0]         wr_colour;
    logic [1:0]         wr_mode;
    logic               commit_pending;
    logic [7:0]         out_r;
    logic [7:0]         out_g;
    logic [7:0]         out_b;
    logic               out_valid;

    int checks = 0;
    int errors = 0;

    // Pixel clock.
    always #5 clk = ~clk;

    vga_rect_multi #(
        .NUM_RECTS (NUM_RECTS),
        .COORD_W   (COORD_W),
        .DASH_LOG2 (DASH_LOG2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .xin            (xin),
        .yin            (yin),
        .frame_start    (frame_start),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_x0          (wr_x0),
        .wr_x1          (wr_x1),
        .wr_y0          (wr_y0),
        .wr_y1          (wr_y1),
        .wr_colour      (wr_colour),
        .wr_mode        (wr_mode),
        .commit_pending (commit_pending),
        .out_r          (out_r),
        .out_g          (out_g),
        .out_b          (out_b),
        .out_valid      (out_valid)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Hand-derived picture for each programmed scene.
    function automatic logic [24:0] expectedPixel(input int scene, input int x, input int y);
        logic outline;
        logic dashLit;
        outline = ((y == 5 || y == 15) && x >= 10 && x <= 20) ||
                  ((x == 10 || x == 20) && y >= 5 && y <= 15);
        dashLit = ((y == 5 || y == 15) && ((x >= 10 && x <= 13) || (x >= 18 && x <= 20))) ||
                  ((x == 10 || x == 20) && ((y >= 6 && y <= 8) || (y >= 13 && y <= 14)));
        case (scene)
            1: return outline ? PIX_RED : PIX_NONE;
            2: return dashLit ? PIX_RED : PIX_NONE;
            3: begin
                if (x <= 50 && y <= 50) return PIX_RED;
                if (x >= 40 && x <= 100 && y >= 40 && y <= 100) return PIX_BLUE;
                return PIX_NONE;
            end
            4: begin
                if (x == 60 && y >= 10 && y <= 20) return PIX_GREEN;
                if (x == 70 && y == 30) return PIX_WHITE;
                return PIX_NONE;
            end
            5: begin
                if (outline) return PIX_RED;
                if (x >= 40 && x <= 100 && y >= 40 && y <= 100) return PIX_BLUE;
                return PIX_NONE;
            end
            6: begin
                if (x <= 50 && y <= 50) return PIX_NONE;
                if (x >= 40 && x <= 100 && y >= 40 && y <= 100) return PIX_BLUE;
                return PIX_NONE;
            end
            default: return PIX_NONE;
        endcase
    endfunction

    // Stream one pixel per clock over a region and check each output two
    // clocks after its coordinates were presented.
    task automatic applyStimulus(input string tag, input int xLo, input int xHi,
                                 input int yLo, input int yHi, input int scene);
        logic [24:0] exp1, exp2;
        int          x1p, y1p, x2p, y2p;
        bit          v1, v2;
        v1 = 1'b0; v2 = 1'b0;
        exp1 = '0; exp2 = '0;
        x1p = 0; y1p = 0; x2p = 0; y2p = 0;
        for (int yy = yLo; yy <= yHi + 1; yy++) begin
            for (int xx = xLo; xx <= ((yy > yHi) ? xLo + 1 : xHi); xx++) begin
                @(negedge clk);
                if (v2)
                    checkOutput($sformatf("%s(%0d,%0d)", tag, x2p, y2p),
                                32'({out_valid, out_r, out_g, out_b}), 32'(exp2));
                exp2 = exp1; v2 = v1; x2p = x1p; y2p = y1p;
                if (yy <= yHi) begin
                    xin  = COORD_W'(xx);
                    yin  = COORD_W'(yy);
                    exp1 = expectedPixel(scene, xx, yy);
                    v1   = 1'b1;
                    x1p  = xx; y1p = yy;
                end else begin
                    v1 = 1'b0;
                end
            end
        end
    endtask

    // Write one slot of the pending bank, optionally with a coincident commit.
    task automatic applyWrite(input int idx, input int x0, input int y0, input int x1,
                              input int y1, input int colour, input int mode,
                              input bit withCommit);
        @(negedge clk);
        wr_en       = 1'b1;
        wr_idx      = IDX_W'(idx);
        wr_x0       = COORD_W'(x0);
        wr_y0       = COORD_W'(y0);
        wr_x1       = COORD_W'(x1);
        wr_y1       = COORD_W'(y1);
        wr_colour   = 5'(colour);
        wr_mode     = 2'(mode);
        frame_start = withCommit;
        @(negedge clk);
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulseFrameStart();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; xin = '0; yin = '0; frame_start = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_x0 = '0; wr_x1 = '0; wr_y0 = '0; wr_y1 = '0;
        wr_colour = '0; wr_mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and an empty picture.
        checkOutput("rstPending", 32'(commit_pending), 32'd0);
        checkOutput("rstPixel", 32'({out_valid, out_r, out_g, out_b}), 32'd0);
        applyStimulus("blank", 0, 63, 0, 15, 0);
        applyStimulus("blankCorner", 630, 639, 470, 479, 0);
        checkOutput("blankPending", 32'(commit_pending), 32'd0);

        // Solid outline: invisible until committed.
        applyWrite(0, 10, 5, 20, 15, 1, M_SOLID, 1'b0);
        checkOutput("wrPending", 32'(commit_pending), 32'd1);
        applyStimulus("preCommit", 10, 10, 5, 5, 0);
        pulseFrameStart();
        checkOutput("commitClears", 32'(commit_pending), 32'd0);
        applyStimulus("solid", 0, 31, 0, 23, 1);

        // Dashed outline of the same rectangle.
        applyWrite(0, 10, 5, 20, 15, 1, M_DASH, 1'b0);
        pulseFrameStart();
        applyStimulus("dash", 0, 31, 0, 23, 2);

        // Two overlapping filled rectangles, lower slot on top.
        applyWrite(0, 0, 0, 50, 50, 1, M_FILL, 1'b0);
        applyWrite(1, 40, 40, 100, 100, 4, M_FILL, 1'b0);
        pulseFrameStart();
        applyStimulus("fillRow45", 0, 110, 45, 45, 3);
        applyStimulus("fillRow60", 0, 110, 60, 60, 3);
        applyStimulus("fillFar", 200, 200, 200, 200, 3);

        // Write coinciding with a commit: old picture stays this frame.
        applyWrite(0, 10, 5, 20, 15, 1, M_SOLID, 1'b1);
        checkOutput("sameCyclePending", 32'(commit_pending), 32'd1);
        applyStimulus("oldGeomA", 5, 5, 5, 5, 3);
        applyStimulus("oldGeomB", 15, 10, 15, 10, 3);
        applyStimulus("oldGeomC", 45, 45, 45, 45, 3);
        pulseFrameStart();
        checkOutput("nextCommitClears", 32'(commit_pending), 32'd0);
        applyStimulus("newGeom", 0, 47, 0, 47, 5);

        // Transparent colour on the winning slot suppresses the pixel.
        applyWrite(0, 0, 0, 50, 50, 0, M_FILL, 1'b0);
        pulseFrameStart();
        applyStimulus("maskRow45", 0, 70, 45, 45, 6);
        applyStimulus("maskRow60", 30, 70, 60, 60, 6);

        // Inverted extents, slot off, one-pixel-wide line and a point.
        applyWrite(0, 30, 0, 20, 50, 1, M_FILL, 1'b0);
        applyWrite(1, 40, 40, 100, 100, 4, M_OFF, 1'b0);
        applyWrite(2, 60, 10, 60, 20, 2, M_SOLID, 1'b0);
        applyWrite(3, 70, 30, 70, 30, 7, M_FILL, 1'b0);
        pulseFrameStart();
        applyStimulus("degen", 0, 79, 0, 45, 4);

        // Reset in mid-frame with an uncommitted write outstanding.
        applyWrite(0, 0, 0, 100, 100, 1, M_FILL, 1'b0);
        @(negedge clk);
        xin = COORD_W'(60);
        yin = COORD_W'(15);
        repeat (2) @(negedge clk);
        checkOutput("preRstLine", 32'({out_valid, out_r, out_g, out_b}), 32'(PIX_GREEN));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstCycle1", 32'({out_valid, out_r, out_g, out_b}), 32'd0);
        @(negedge clk);
        checkOutput("rstCycle2", 32'({out_valid, out_r, out_g, out_b}), 32'd0);
        checkOutput("rstDropsPending", 32'(commit_pending), 32'd0);
        pulseFrameStart();
        applyStimulus("afterRst", 0, 79, 0, 45, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rect_multi.md
Name: vga_rect_multi

Overview:
- Multi-rectangle overlay generator for the VGA pixel path.
- Holds NUM_RECTS programmable rectangles. Each has its own extents, 5-bit colour code and draw mode: solid outline, dashed outline, filled, or off.
- Rectangle registers are double-buffered and committed at frame start, so updates never tear mid-frame.
- Pixel output is registered with fixed latency plus an explicit valid flag; the downstream mixer uses the flag instead of tri-state.

Parameters:
- NUM_RECTS, 4, number of rectangle slots (1..16).
- COORD_W, 10, width of x/y coordinates.
- DASH_LOG2, 2, dash segment length is 2^DASH_LOG2 pixels.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- xin  in  COORD_W  current x, connect to pix_x
- yin  in  COORD_W  current y, connect to pix_y
- frame_start  in  1  one-cycle pulse at start of vertical blank
- wr_en  in  1  write strobe for the pending bank
- wr_idx  in  IDX_W=max(1,clog2(NUM_RECTS))  slot to write
- wr_x0, wr_x1, wr_y0, wr_y1  in  COORD_W each  extents; (x0,y0) top-left, (x1,y1) bottom-right
- wr_colour  in  5  colour code for vga_colour
- wr_mode  in  2  00 solid outline, 01 dashed outline, 10 filled, 11 off
- commit_pending  out  1  pending bank differs from active (written since last commit)
- out_r, out_g, out_b  out  8 each  pixel colour
- out_valid  out  1  1 = overlay pixel present, mixer must use out_r/g/b

Behaviour:
- Reset:
  - All active and pending slots become mode 11 with coords 0 and colour 0.
  - commit_pending=0; out_r/g/b=0; out_valid=0.
  - Reset mid-frame discards uncommitted writes.
- Write:
  - When wr_en=1, all fields of slot wr_idx in the pending bank update on the next edge, and commit_pending is set.
  - wr_idx >= NUM_RECTS is ignored; commit_pending is unchanged.
- Commit:
  - When frame_start=1, the whole pending bank is copied to the active bank and commit_pending clears.
  - If wr_en and frame_start are both 1 in the same cycle, the copy uses the pre-write pending contents. The write lands in pending and commit_pending stays 1; it becomes visible next frame.
  - frame_start with nothing pending still copies, which is harmless.
- Hit test (active bank, per slot, unsigned compare):
  - inside = x0<=xin<=x1 and y0<=yin<=y1.
  - edge = inside and (xin==x0 or xin==x1 or yin==y0 or yin==y1).
  - Mode 00: hit = edge.
  - Mode 01: hit = edge and dash_on. On a horizontal edge (yin==y0 or y1), dash_on = bit DASH_LOG2 of (xin-x0) is 0. On vertical-only edges, use (yin-y0) instead. Differences are COORD_W-bit modulo.
  - Mode 10: hit = inside.
  - Mode 11: never hits.
  - Degenerate extents: x0>x1 or y0>y1 gives no hit. x0==x1 draws a vertical line; a point is allowed.
- Priority: the lowest-index hitting slot wins.
- Pipeline, latency 2 clocks from xin/yin to outputs:
  - Stage 1 registers any_hit and the winning colour code.
  - Stage 2 registers the vga_colour result.
  - out_valid = stage-1 any_hit AND c_mask. With c_mask=0 (transparent), out_valid=0.
  - When out_valid=0, out_r/g/b are driven 0.
- An active-bank change at frame_start affects pixels sampled from the following cycle on. Pixels already in the pipeline complete with old data.

Decomposition:
- Shared package vga_pkg holds:
  - MODE_SOLID=2'b00, MODE_DASH=2'b01, MODE_FILL=2'b10, MODE_OFF=2'b11.
  - COLOUR_W=5.
  - A rectangle record typedef: x0, x1, y0, y1, colour, mode.
- Sub-module vga_rect_hit: combinational per-slot hit test with mode and dash logic, instantiated NUM_RECTS times.
- Existing vga_colour is instantiated once, after priority selection.

Test Plan:
- Reset, no writes, sweep a full 640x480 frame -> out_valid never 1, out_r/g/b=0, commit_pending=0.
- Write slot0 = (10,5)-(20,15), colour red, mode 00; pulse frame_start -> out_valid=1 exactly at (10..20,5), (10..20,15), (10,5..15), (20,5..15), appearing 2 cycles after xin/yin; (15,10) gives out_valid=0.
- Same slot in mode 01 with DASH_LOG2=2 -> top edge lit at x=10..13 and 18..20, dark at x=14..17; left edge lit at y=5..8 and 13..15.
- Slot0 filled red (0,0)-(50,50), slot1 filled blue (40,40)-(100,100) -> (45,45) red, (60,60) blue, (200,200) invalid.
- Write slot0 in the same cycle as frame_start -> old geometry drawn this frame, commit_pending=1; new geometry drawn after the next frame_start.
- Colour code with c_mask=0 on a hitting rectangle -> out_valid=0. Set x0=30, x1=20 -> no hits anywhere. Assert rst mid-frame -> next two cycles out_valid=0, all slots off.
